clint: RTL and testbench

Core-local interruptor for the wolv-z1 core. Sits on the core's memory bus behind the address decode and serves memory-mapped reads and writes of `msip`, `mtimecmp` and `mtime`. Drives the `soft_irpt` and `timer_irpt` inputs of `cpu`. It holds a 64-bit real-time counter, a compare register and the software-interrupt bit, and answers each bus request with a fixed one-cycle registered response.

---
 rtl/clint_pkg.sv | 33 +++
 rtl/clint_rtc.sv | 47 ++++
 rtl/clint.sv | 120 ++++++++++++
 tb/tb_clint.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// clint_pkg: shared definitions for the core-local interruptor.
//   - register offsets of the memory map (byte offsets in the 64 KiB window)
//   - default mtime prescaler ratio and prescaler width
//   - bus FSM state type
//   - byte-lane merge helper used by every writable register
package clint_pkg;

  localparam logic [15:0] clint_msip     = 16'h0000;
  localparam logic [15:0] clint_mtimecmp = 16'h4000;
  localparam logic [15:0] clint_mtime    = 16'hBFF8;

  localparam int unsigned rtc_div_default = 1;
  // Prescaler holds 0..rtc_div-1; rtc_div tops out at 2^16.
  localparam int unsigned prescale_w      = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } clint_state_type;

  // Replace the byte lanes of old_val selected by wstrb with wdata.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_rtc.sv
// clint_rtc: prescaled 64-bit real-time counter (mtime).
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   wr_lo, wr_hi   - bus write strobes for mtime[31:0] / mtime[63:32]
//   wstrb, wdata   - byte strobes and data of the bus write
//   mtime          - current counter value
module clint_rtc
  import clint_pkg::*;
#(
  parameter int unsigned rtc_div = rtc_div_default
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic [63:0] mtime
);

  localparam logic [prescale_w-1:0] presc_max = prescale_w'(rtc_div - 1);

  logic [prescale_w-1:0] r_presc;
  logic [63:0]           r_mtime;
  logic                  w_tick;

  assign w_tick = (r_presc == presc_max);
  assign mtime  = r_mtime;

  // Prescaler free-runs regardless of mtime writes. A write drops the
  // coincident increment entirely, so the unwritten half keeps its value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_mtime <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + prescale_w'(1);
      if (wr_lo || wr_hi) begin
        if (wr_lo) r_mtime[31:0]  <= merge_bytes(r_mtime[31:0], wdata, wstrb);
        if (wr_hi) r_mtime[63:32] <= merge_bytes(r_mtime[63:32], wdata, wstrb);
      end else if (w_tick) begin
        r_mtime <= r_mtime + 64'd1;
      end
    end
  end

endmodule

// File: rtl/clint.sv
// clint: core-local interruptor (msip, mtimecmp, mtime) on the core memory bus.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   memory_valid/instr/addr      - request strobe, fetch flag (read), byte address
//   memory_wdata, memory_wstrb   - write data and byte strobes (0 = read)
//   memory_rdata, memory_ready   - registered one-cycle response
//   soft_irpt                    - msip[0]
//   timer_irpt                   - registered mtime >= mtimecmp
module clint
  import clint_pkg::*;
#(
  parameter int unsigned rtc_div = rtc_div_default
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memory_valid,
  input  logic        memory_instr,
  input  logic [31:0] memory_addr,
  input  logic [31:0] memory_wdata,
  input  logic [3:0]  memory_wstrb,
  output logic [31:0] memory_rdata,
  output logic        memory_ready,
  output logic        soft_irpt,
  output logic        timer_irpt
);

  clint_state_type r_state;
  logic            r_msip;
  logic [63:0]     r_mtimecmp;
  logic            r_timer;
  logic            r_ready;
  logic [31:0]     r_rdata;

  logic [63:0]     w_mtime;
  logic [13:0]     w_word;
  logic            w_accept;
  logic            w_write;
  logic            w_sel_msip;
  logic            w_sel_cmp_lo;
  logic            w_sel_cmp_hi;
  logic            w_sel_time_lo;
  logic            w_sel_time_hi;
  logic [31:0]     w_rdata;
  logic            w_unused;

  // Only the word offset inside the window is decoded.
  assign w_word   = memory_addr[15:2];
  assign w_unused = ^{memory_addr[31:16], memory_addr[1:0]};

  assign w_accept = (r_state == IDLE) && memory_valid;
  // Fetches are reads even if strobes are set.
  assign w_write  = w_accept && !memory_instr && (memory_wstrb != 4'b0000);

  assign w_sel_msip    = (w_word == clint_msip[15:2]);
  assign w_sel_cmp_lo  = (w_word == clint_mtimecmp[15:2]);
  assign w_sel_cmp_hi  = (w_word == clint_mtimecmp[15:2] + 14'd1);
  assign w_sel_time_lo = (w_word == clint_mtime[15:2]);
  assign w_sel_time_hi = (w_word == clint_mtime[15:2] + 14'd1);

  clint_rtc #(
    .rtc_div (rtc_div)
  ) u_rtc (
    .clk   (clk),
    .rst   (rst),
    .wr_lo (w_write && w_sel_time_lo),
    .wr_hi (w_write && w_sel_time_hi),
    .wstrb (memory_wstrb),
    .wdata (memory_wdata),
    .mtime (w_mtime)
  );

  // Read mux on pre-edge register values; unmapped offsets read 0.
  always_comb begin
    w_rdata = '0;
    if (w_sel_msip)         w_rdata = {31'b0, r_msip};
    else if (w_sel_cmp_lo)  w_rdata = r_mtimecmp[31:0];
    else if (w_sel_cmp_hi)  w_rdata = r_mtimecmp[63:32];
    else if (w_sel_time_lo) w_rdata = w_mtime[31:0];
    else if (w_sel_time_hi) w_rdata = w_mtime[63:32];
  end

  // Bus FSM, msip/mtimecmp writes and the registered timer compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ready    <= 1'b0;
      r_rdata    <= '0;
      r_msip     <= 1'b0;
      r_mtimecmp <= '1;
      r_timer    <= 1'b0;
    end else begin
      r_timer <= (w_mtime >= r_mtimecmp);
      case (r_state)
        IDLE: begin
          r_ready <= 1'b0;
          if (memory_valid) begin
            r_state <= RESP;
            r_ready <= 1'b1;
            r_rdata <= w_rdata;
          end
        end
        RESP: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
        end
      endcase
      if (w_write && w_sel_msip && memory_wstrb[0]) r_msip <= memory_wdata[0];
      if (w_write && w_sel_cmp_lo)
        r_mtimecmp[31:0] <= merge_bytes(r_mtimecmp[31:0], memory_wdata, memory_wstrb);
      if (w_write && w_sel_cmp_hi)
        r_mtimecmp[63:32] <= merge_bytes(r_mtimecmp[63:32], memory_wdata, memory_wstrb);
    end
  end

  assign memory_ready = r_ready;
  assign memory_rdata = r_rdata;
  assign soft_irpt    = r_msip;
  assign timer_irpt   = r_timer;

endmodule

// File: tb/tb_clint.sv
// tb_clint: randomized bench for clint with a cycle-level reference model.
module tb_clint;

  localparam int unsigned DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        memory_valid;
  logic        memory_instr;
  logic [31:0] memory_addr;
  logic [31:0] memory_wdata;
  logic [3:0]  memory_wstrb;
  logic [31:0] memory_rdata;
  logic        memory_ready;
  logic        soft_irpt;
  logic        timer_irpt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  clint #(.rtc_div(DIV)) dut (
    .clk          (clk),
    .rst          (rst),
    .memory_valid (memory_valid),
    .memory_instr (memory_instr),
    .memory_addr  (memory_addr),
    .memory_wdata (memory_wdata),
    .memory_wstrb (memory_wstrb),
    .memory_rdata (memory_rdata),
    .memory_ready (memory_ready),
    .soft_irpt    (soft_irpt),
    .timer_irpt   (timer_irpt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] d,
                                         input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Reference model: architectural state as plain numbers.
  bit          m_busy, m_ready, m_msip, m_timer;
  logic [31:0] m_rdata;
  logic [63:0] m_mtime, m_cmp;
  int unsigned m_tick;

  always @(posedge clk) begin
    logic [63:0] n_mtime, n_cmp;
    logic [31:0] n_rdata;
    logic [15:0] off;
    bit          n_msip, n_ready, n_timer;
    if (rst) begin
      m_busy = 0; m_ready = 0; m_msip = 0; m_timer = 0;
      m_rdata = 0; m_mtime = 0; m_cmp = '1; m_tick = 0;
    end else begin
      n_timer = (m_mtime >= m_cmp);
      n_mtime = m_mtime;
      if (m_tick == DIV - 1) begin
        m_tick  = 0;
        n_mtime = m_mtime + 64'd1;
      end else begin
        m_tick = m_tick + 1;
      end
      n_cmp = m_cmp; n_msip = m_msip; n_rdata = m_rdata; n_ready = 0;
      if (!m_busy && memory_valid) begin
        n_ready = 1;
        off = {memory_addr[15:2], 2'b00};
        case (off)
          16'h0000: n_rdata = {31'b0, m_msip};
          16'h4000: n_rdata = m_cmp[31:0];
          16'h4004: n_rdata = m_cmp[63:32];
          16'hBFF8: n_rdata = m_mtime[31:0];
          16'hBFFC: n_rdata = m_mtime[63:32];
          default:  n_rdata = 0;
        endcase
        if (memory_wstrb != 0 && !memory_instr) begin
          case (off)
            16'h0000: if (memory_wstrb[0]) n_msip = memory_wdata[0];
            16'h4000: n_cmp[31:0]  = bmerge(m_cmp[31:0], memory_wdata, memory_wstrb);
            16'h4004: n_cmp[63:32] = bmerge(m_cmp[63:32], memory_wdata, memory_wstrb);
            16'hBFF8: n_mtime = {m_mtime[63:32], bmerge(m_mtime[31:0], memory_wdata, memory_wstrb)};
            16'hBFFC: n_mtime = {bmerge(m_mtime[63:32], memory_wdata, memory_wstrb), m_mtime[31:0]};
            default: ;
          endcase
        end
      end
      m_busy = n_ready; m_ready = n_ready; m_rdata = n_rdata;
      m_msip = n_msip; m_cmp = n_cmp; m_mtime = n_mtime; m_timer = n_timer;
    end
    #1;
    check("ready", memory_ready, m_ready);
    check("soft_irpt", soft_irpt, m_msip);
    check("timer_irpt", timer_irpt, m_timer);
    if (m_ready) check("rdata", memory_rdata, m_rdata);
  end

  task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input bit ins, output logic [31:0] rd, output int lat);
    bit got;
    got = 0; lat = 0; rd = '0;
    @(posedge clk); #2;
    memory_valid = 1; memory_addr = a; memory_wdata = d;
    memory_wstrb = s; memory_instr = ins;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #2;
      if (memory_ready) begin got = 1; rd = memory_rdata; lat = i + 1; end
    end
    memory_valid = 0; memory_wstrb = 0; memory_instr = 0;
    check("xfer_done", got, 1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd; int lat;
    xfer(a, d, s, 0, rd, lat);
  endtask

  task automatic rdw(input logic [31:0] a, output logic [31:0] rd);
    int lat;
    xfer(a, 0, 0, 0, rd, lat);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, a;
    int          lat, cnt, b2b;
    bit          prev, seen;

    rst = 1; memory_valid = 0; memory_instr = 0;
    memory_addr = 0; memory_wdata = 0; memory_wstrb = 0;
    repeat (3) @(posedge clk);
    #2 rst = 0;

    // Reset state and first read of mtimecmp hi.
    #0 check("rst_rdata", memory_rdata, 0);
    xfer(32'h4004, 0, 0, 0, rd, lat);
    check("cmp_hi_rst", rd, 32'hFFFF_FFFF);
    check("latency", lat, 1);
    check("timer_after_rst", timer_irpt, 0);

    // msip byte-0 writes.
    wr(32'h0, 32'h1, 4'h1);
    check("msip_set", soft_irpt, 1);
    wr(32'h0, 32'h0, 4'h1);
    check("msip_clr", soft_irpt, 0);
    wr(32'h0, 32'h1, 4'h1);
    wr(32'h0, 32'h100, 4'h2);
    check("msip_byte1", soft_irpt, 1);
    rdw(32'h0, rd);
    check("msip_read", rd, 1);

    // mtime carry across the 32-bit boundary.
    wr(32'hBFF8, 32'hFFFF_FFFE, 4'hF);
    wr(32'hBFFC, 32'h0, 4'hF);
    repeat (12) @(posedge clk);
    rdw(32'hBFF8, rd);
    rdw(32'hBFFC, rd);
    check("mtime_carry_hi", rd, 1);

    // Timer interrupt rise and fall.
    wr(32'h4004, 32'h0, 4'hF);
    wr(32'h4000, 32'h10, 4'hF);
    wr(32'hBFF8, 32'h0, 4'hF);
    wr(32'hBFFC, 32'h0, 4'hF);
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(posedge clk); #2;
      if (timer_irpt) seen = 1;
    end
    check("timer_rise", seen, 1);
    rdw(32'hBFF8, rd);
    check("mtime_past_cmp", rd >= 32'h10, 1);
    wr(32'h4004, 32'hFFFF_FFFF, 4'hF);
    @(posedge clk); #2;
    check("timer_fall", timer_irpt, 0);

    // Continuous valid on an unmapped offset.
    repeat (2) @(posedge clk);
    #2 memory_valid = 1; memory_addr = 32'h1234; memory_wstrb = 0;
    cnt = 0; b2b = 0; prev = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (memory_ready) begin
        cnt++;
        if (prev) b2b++;
        check("stream_rdata", memory_rdata, 0);
      end
      prev = memory_ready;
    end
    memory_valid = 0;
    check("stream_pulses", cnt, 10);
    check("stream_b2b", b2b, 0);

    // Reset coinciding with acceptance, then reset during RESP.
    repeat (2) @(posedge clk);
    #2 memory_valid = 1; memory_addr = 32'hBFF8; rst = 1;
    @(posedge clk); #2;
    check("rst_no_ready", memory_ready, 0);
    rst = 0; memory_valid = 0;
    wr(32'h0, 32'h1, 4'h1);
    wr(32'h4000, 32'h5, 4'hF);
    @(posedge clk); #2;
    memory_valid = 1; memory_addr = 32'h4000;
    @(posedge clk); #2;
    memory_valid = 0; rst = 1;
    @(posedge clk); #2;
    rst = 0;
    check("resp_rst_ready", memory_ready, 0);
    check("resp_rst_rdata", memory_rdata, 0);
    check("resp_rst_soft", soft_irpt, 0);
    rdw(32'h4000, rd);
    check("resp_rst_cmp_lo", rd, 32'hFFFF_FFFF);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      logic [3:0] s;
      case ($urandom_range(0, 5))
        0: a = 32'h0000;
        1: a = 32'h4000;
        2: a = 32'h4004;
        3: a = 32'hBFF8;
        4: a = 32'hBFFC;
        default: a = $urandom & 32'h0000_FFFC;
      endcase
      a = a | ($urandom & 32'hFFFF_0003);
      s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      if (a[15:2] == 14'h2FFE || a[15:2] == 14'h2FFF) s = (s != 0) ? 4'hF : 4'h0;
      xfer(a, $urandom, s, ($urandom_range(0, 7) == 0), rd, lat);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      if ($urandom_range(0, 49) == 0) begin
        #2 rst = 1;
        @(posedge clk); #2 rst = 0;
      end
    end

    repeat (3) @(posedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
